// File: rtl/reg_bus_arbiter_pkg.sv
// Shared types and constants for the two-requester register bus arbiter.
package reg_bus_pkg;

  localparam int DEF_NUM_REGS = 8;
  localparam int DEF_ADDR_W   = 3;

  localparam logic [7:0] BAD_ADDR_RDATA = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } arb_state_e;

endpackage

// File: rtl/reg_bus_arbiter_if.sv
// Requester handshakes plus the shared register bus, bundled for the arbiter.
interface reg_bus_arbiter_if #(
  parameter int NUM_REGS = reg_bus_pkg::DEF_NUM_REGS,
  parameter int ADDR_W   = reg_bus_pkg::DEF_ADDR_W
);

  logic                a_req;
  logic                b_req;
  logic                a_we;
  logic                b_we;
  logic [ADDR_W-1:0]   a_addr;
  logic [ADDR_W-1:0]   b_addr;
  logic [7:0]          a_wdata;
  logic [7:0]          b_wdata;
  logic                a_ack;
  logic                b_ack;
  logic [7:0]          a_rdata;
  logic [7:0]          b_rdata;
  logic [NUM_REGS-1:0] reg_cs;
  logic                reg_we;
  logic [7:0]          reg_wdata;
  logic [7:0]          reg_rdata;

  modport arb (
    input  a_req, b_req, a_we, b_we, a_addr, b_addr, a_wdata, b_wdata, reg_rdata,
    output a_ack, b_ack, a_rdata, b_rdata, reg_cs, reg_we, reg_wdata
  );

  modport env (
    output a_req, b_req, a_we, b_we, a_addr, b_addr, a_wdata, b_wdata, reg_rdata,
    input  a_ack, b_ack, a_rdata, b_rdata, reg_cs, reg_we, reg_wdata
  );

endinterface

// File: rtl/reg_bus_arbiter_addr_decode.sv
// Register index to one-hot chip select; indices past NUM_REGS select nothing.
module reg_addr_decode #(
  parameter int NUM_REGS = reg_bus_pkg::DEF_NUM_REGS,
  parameter int ADDR_W   = reg_bus_pkg::DEF_ADDR_W
) (
  input  logic [ADDR_W-1:0]   addr,
  output logic [NUM_REGS-1:0] onehot,
  output logic                out_of_range
);

  // compare the index against every implemented register
  always_comb begin
    onehot       = {NUM_REGS{1'b0}};
    out_of_range = 1'b1;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (addr == ADDR_W'(i)) begin
        onehot[i]    = 1'b1;
        out_of_range = 1'b0;
      end else begin
        onehot[i]    = 1'b0;
      end
    end
  end

endmodule

// File: rtl/reg_bus_arbiter.sv
// Round-robin arbiter giving requesters A and B turns on a shared 8-bit register bus.
module reg_bus_arbiter
  import reg_bus_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = DEF_ADDR_W
) (
  input  logic            clk,
  input  logic            rst,
  reg_bus_arbiter_if.arb  bus
);

  arb_state_e          state_q, state_d;
  logic                prio_b_q, prio_b_d;
  logic                gnt_b_q, gnt_b_d;
  logic                we_q, we_d;
  logic                oor_q, oor_d;
  logic [NUM_REGS-1:0] reg_cs_q, reg_cs_d;
  logic                reg_we_q, reg_we_d;
  logic [7:0]          reg_wdata_q, reg_wdata_d;
  logic                a_ack_q, a_ack_d;
  logic                b_ack_q, b_ack_d;
  logic [7:0]          a_rdata_q, a_rdata_d;
  logic [7:0]          b_rdata_q, b_rdata_d;

  logic                pick_b_s;
  logic [ADDR_W-1:0]   sel_addr_s;
  logic [NUM_REGS-1:0] sel_onehot_s;
  logic                sel_oor_s;
  logic [7:0]          rd_value_s;

  // prio_b_q set means B wins the next tie
  always_comb begin
    if (bus.a_req && bus.b_req) begin
      pick_b_s = prio_b_q;
    end else if (bus.b_req) begin
      pick_b_s = 1'b1;
    end else begin
      pick_b_s = 1'b0;
    end
    sel_addr_s = pick_b_s ? bus.b_addr : bus.a_addr;
  end

  reg_addr_decode #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_decode (
    .addr         (sel_addr_s),
    .onehot       (sel_onehot_s),
    .out_of_range (sel_oor_s)
  );

  // data returned to the requester at the end of the access
  always_comb begin
    if (we_q) begin
      rd_value_s = 8'h00;
    end else if (oor_q) begin
      rd_value_s = BAD_ADDR_RDATA;
    end else begin
      rd_value_s = bus.reg_rdata;
    end
  end

  // next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    prio_b_d    = prio_b_q;
    gnt_b_d     = gnt_b_q;
    we_d        = we_q;
    oor_d       = oor_q;
    reg_cs_d    = {NUM_REGS{1'b0}};
    reg_we_d    = 1'b0;
    reg_wdata_d = 8'h00;
    a_ack_d     = 1'b0;
    b_ack_d     = 1'b0;
    a_rdata_d   = a_rdata_q;
    b_rdata_d   = b_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.a_req || bus.b_req) begin
          state_d     = ST_ACCESS;
          gnt_b_d     = pick_b_s;
          prio_b_d    = ~pick_b_s;
          we_d        = pick_b_s ? bus.b_we : bus.a_we;
          oor_d       = sel_oor_s;
          reg_cs_d    = sel_oor_s ? {NUM_REGS{1'b0}} : sel_onehot_s;
          reg_we_d    = we_d & ~sel_oor_s;
          reg_wdata_d = pick_b_s ? bus.b_wdata : bus.a_wdata;
        end else begin
          state_d     = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        state_d = ST_DONE;
        if (gnt_b_q) begin
          b_ack_d   = 1'b1;
          b_rdata_d = rd_value_s;
        end else begin
          a_ack_d   = 1'b1;
          a_rdata_d = rd_value_s;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // state and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      prio_b_q    <= 1'b0;
      gnt_b_q     <= 1'b0;
      we_q        <= 1'b0;
      oor_q       <= 1'b0;
      reg_cs_q    <= {NUM_REGS{1'b0}};
      reg_we_q    <= 1'b0;
      reg_wdata_q <= 8'h00;
      a_ack_q     <= 1'b0;
      b_ack_q     <= 1'b0;
      a_rdata_q   <= 8'h00;
      b_rdata_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      prio_b_q    <= prio_b_d;
      gnt_b_q     <= gnt_b_d;
      we_q        <= we_d;
      oor_q       <= oor_d;
      reg_cs_q    <= reg_cs_d;
      reg_we_q    <= reg_we_d;
      reg_wdata_q <= reg_wdata_d;
      a_ack_q     <= a_ack_d;
      b_ack_q     <= b_ack_d;
      a_rdata_q   <= a_rdata_d;
      b_rdata_q   <= b_rdata_d;
    end
  end

  assign bus.reg_cs    = reg_cs_q;
  assign bus.reg_we    = reg_we_q;
  assign bus.reg_wdata = reg_wdata_q;
  assign bus.a_ack     = a_ack_q;
  assign bus.b_ack     = b_ack_q;
  assign bus.a_rdata   = a_rdata_q;
  assign bus.b_rdata   = b_rdata_q;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Drives an 8-register and a 6-register arbiter with identical stimulus and
// checks both against a transaction-level model of the arbitration rules.
module tb_reg_bus_arbiter;
  import reg_bus_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       a_req, b_req, a_we, b_we;
  logic [2:0] a_addr, b_addr;
  logic [7:0] a_wdata, b_wdata;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  reg_bus_arbiter_if #(.NUM_REGS(8), .ADDR_W(3)) bus8 ();
  reg_bus_arbiter_if #(.NUM_REGS(6), .ADDR_W(3)) bus6 ();

  assign bus8.a_req = a_req;     assign bus6.a_req = a_req;
  assign bus8.b_req = b_req;     assign bus6.b_req = b_req;
  assign bus8.a_we = a_we;       assign bus6.a_we = a_we;
  assign bus8.b_we = b_we;       assign bus6.b_we = b_we;
  assign bus8.a_addr = a_addr;   assign bus6.a_addr = a_addr;
  assign bus8.b_addr = b_addr;   assign bus6.b_addr = b_addr;
  assign bus8.a_wdata = a_wdata; assign bus6.a_wdata = a_wdata;
  assign bus8.b_wdata = b_wdata; assign bus6.b_wdata = b_wdata;

  reg_bus_arbiter #(.NUM_REGS(8), .ADDR_W(3)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8));
  reg_bus_arbiter #(.NUM_REGS(6), .ADDR_W(3)) u_dut6 (.clk(clk), .rst(rst), .bus(bus6));

  // Register banks on each bus; an idle bus reads as 8'hEE so stray captures show up
  logic [7:0] regs8 [8];
  logic [7:0] regs6 [6];
  logic [7:0] rd8, rd6;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) regs8[i] <= 8'h10 + 8'(i);
      for (int i = 0; i < 6; i++) regs6[i] <= 8'h10 + 8'(i);
    end else begin
      for (int i = 0; i < 8; i++) if (bus8.reg_we && bus8.reg_cs[i]) regs8[i] <= bus8.reg_wdata;
      for (int i = 0; i < 6; i++) if (bus6.reg_we && bus6.reg_cs[i]) regs6[i] <= bus6.reg_wdata;
    end
  end

  always_comb begin
    rd8 = 8'hEE;
    rd6 = 8'hEE;
    for (int i = 0; i < 8; i++) if (bus8.reg_cs[i] && !bus8.reg_we) rd8 = regs8[i];
    for (int i = 0; i < 6; i++) if (bus6.reg_cs[i] && !bus6.reg_we) rd6 = regs6[i];
  end
  assign bus8.reg_rdata = rd8;
  assign bus6.reg_rdata = rd6;

  // Reference model state: register contents, who was served last, held rdata per requester
  logic [7:0] mem8 [8];
  logic [7:0] mem6 [6];
  logic [7:0] hold8 [2];
  logic [7:0] hold6 [2];
  bit         last_was_a;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mem8[i] = 8'h10 + 8'(i);
    for (int i = 0; i < 6; i++) mem6[i] = 8'h10 + 8'(i);
    hold8[0] = 8'h00; hold8[1] = 8'h00;
    hold6[0] = 8'h00; hold6[1] = 8'h00;
    last_was_a = 1'b0;
  endtask

  function automatic logic [7:0] onehot8(input logic [2:0] addr, input int nregs);
    logic [7:0] v;
    v = 8'h00;
    if (int'(addr) < nregs) v[addr] = 1'b1;
    return v;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_cs8"}, 32'(bus8.reg_cs), 32'd0);
    check({tag, "_cs6"}, 32'(bus6.reg_cs), 32'd0);
    check({tag, "_we"}, 32'({bus8.reg_we, bus6.reg_we}), 32'd0);
    check({tag, "_wdata"}, 32'({bus8.reg_wdata, bus6.reg_wdata}), 32'd0);
    check({tag, "_acks"}, 32'({bus8.a_ack, bus8.b_ack, bus6.a_ack, bus6.b_ack}), 32'd0);
    check({tag, "_rdata8"}, 32'({bus8.a_rdata, bus8.b_rdata}), 32'd0);
    check({tag, "_rdata6"}, 32'({bus6.a_rdata, bus6.b_rdata}), 32'd0);
  endtask

  // One arbitrated access starting in an idle cycle; returns which requester won
  task automatic run_txn(input logic ra, input logic rb, input logic wa, input logic wb,
                         input logic [2:0] aa, input logic [2:0] ab,
                         input logic [7:0] da, input logic [7:0] db,
                         input bit drop_early, output bit win_b);
    logic       w;
    logic [2:0] ad;
    logic [7:0] wd;
    a_req = ra; b_req = rb; a_we = wa; b_we = wb;
    a_addr = aa; b_addr = ab; a_wdata = da; b_wdata = db;
    win_b = (ra && rb) ? last_was_a : rb;
    last_was_a = !win_b;
    w  = win_b ? wb : wa;
    ad = win_b ? ab : aa;
    wd = win_b ? db : da;
    hold8[win_b] = w ? 8'h00 : mem8[ad];
    hold6[win_b] = w ? 8'h00 : ((ad < 3'd6) ? mem6[ad] : BAD_ADDR_RDATA);
    if (w) begin
      mem8[ad] = wd;
      if (ad < 3'd6) mem6[ad] = wd;
    end

    tick();
    if (drop_early) begin a_req = 1'b0; b_req = 1'b0; end
    check("access_cs8", 32'(bus8.reg_cs), 32'(onehot8(ad, 8)));
    check("access_cs6", 32'(bus6.reg_cs), 32'(onehot8(ad, 6)));
    check("access_we8", 32'(bus8.reg_we), 32'(w));
    check("access_we6", 32'(bus6.reg_we), 32'(w && (ad < 3'd6)));
    check("access_wdata", 32'({bus8.reg_wdata, bus6.reg_wdata}), 32'({wd, wd}));
    check("access_acks", 32'({bus8.a_ack, bus8.b_ack, bus6.a_ack, bus6.b_ack}), 32'd0);

    tick();
    check("done_ack8", 32'({bus8.a_ack, bus8.b_ack}), 32'({!win_b, win_b}));
    check("done_ack6", 32'({bus6.a_ack, bus6.b_ack}), 32'({!win_b, win_b}));
    check("done_rdata8", 32'({bus8.a_rdata, bus8.b_rdata}), 32'({hold8[0], hold8[1]}));
    check("done_rdata6", 32'({bus6.a_rdata, bus6.b_rdata}), 32'({hold6[0], hold6[1]}));
    check("done_cs", 32'({bus8.reg_cs, bus6.reg_cs, bus8.reg_we, bus6.reg_we}), 32'd0);
    if (win_b) b_req = 1'b0; else a_req = 1'b0;

    tick();
    check("after_acks", 32'({bus8.a_ack, bus8.b_ack, bus6.a_ack, bus6.b_ack}), 32'd0);
    check("after_rdata8", 32'({bus8.a_rdata, bus8.b_rdata}), 32'({hold8[0], hold8[1]}));
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 8; i++) check({tag, "_regs8"}, 32'(regs8[i]), 32'(mem8[i]));
    for (int i = 0; i < 6; i++) check({tag, "_regs6"}, 32'(regs6[i]), 32'(mem6[i]));
  endtask

  initial begin
    bit win;
    a_req = 1'b0; b_req = 1'b0; a_we = 1'b0; b_we = 1'b0;
    a_addr = 3'd0; b_addr = 3'd0; a_wdata = 8'h00; b_wdata = 8'h00;
    rst = 1'b1;
    model_reset();
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;

    repeat (3) tick();
    check_all_zero("idle_noreq");

    // A writes 0x5A to reg 3, then B reads it back
    run_txn(1'b1, 1'b0, 1'b1, 1'b0, 3'd3, 3'd0, 8'h5A, 8'h00, 1'b0, win);
    check("write_reg3", 32'(regs8[3]), 32'h5A);
    run_txn(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd3, 8'h00, 8'h00, 1'b0, win);
    check("read_reg3_b_rdata", 32'(bus8.b_rdata), 32'h5A);
    check("read_reg3_winner", 32'(win), 32'd1);

    // continuous contention alternates A, B, A, B
    for (int i = 0; i < 6; i++) begin
      run_txn(1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
              8'($urandom), 8'($urandom), 1'b0, win);
      check("contention_order", 32'(win), 32'(i % 2));
    end

    // reset during a write access
    a_req = 1'b1; b_req = 1'b0; a_we = 1'b1; a_addr = 3'd5; a_wdata = 8'hC3;
    tick();
    check("pre_rst_cs", 32'(bus8.reg_cs), 32'h20);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_all_zero("rst_mid");
    a_req = 1'b0;
    tick();
    check_all_zero("rst_hold");
    rst = 1'b0;
    tick();
    check("rst_no_ack", 32'({bus8.a_ack, bus8.b_ack, bus8.reg_cs}), 32'd0);
    run_txn(1'b1, 1'b1, 1'b0, 1'b1, 3'd1, 3'd2, 8'h00, 8'h99, 1'b0, win);
    check("rst_first_grant_a", 32'(win), 32'd0);

    // A drops req during ACCESS; the write still completes
    run_txn(1'b1, 1'b0, 1'b1, 1'b0, 3'd6, 3'd0, 8'h3C, 8'h00, 1'b1, win);
    check("early_drop_reg6", 32'(regs8[6]), 32'h3C);

    // out-of-range accesses on the 6-register bus
    run_txn(1'b1, 1'b0, 1'b0, 1'b0, 3'd7, 3'd0, 8'h00, 8'h00, 1'b0, win);
    check("oor_read_rdata", 32'(bus6.a_rdata), 32'hFF);
    run_txn(1'b1, 1'b0, 1'b1, 1'b0, 3'd6, 3'd0, 8'h77, 8'h00, 1'b0, win);
    check("oor_write_rdata", 32'(bus6.a_rdata), 32'h00);
    check_regs("oor_write");

    // randomized traffic with occasional idle gaps
    for (int k = 0; k < 40; k++) begin
      int sel;
      sel = int'($urandom_range(1, 3));
      run_txn(1'(sel & 1), 1'((sel >> 1) & 1), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
              8'($urandom), 8'($urandom), ($urandom_range(0, 4) == 0), win);
      if ($urandom_range(0, 3) == 0) begin
        a_req = 1'b0; b_req = 1'b0;
        tick();
        check("gap_idle", 32'({bus8.reg_cs, bus8.a_ack, bus8.b_ack, bus6.a_ack, bus6.b_ack}), 32'd0);
      end
    end
    check_regs("final");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/reg_bus_arbiter.md
REG_BUS_ARBITER -- requirements
Module: reg_bus_arbiter

Interface
REQ-001 SHALL have parameter NUM_REGS, default 8: number of 8-bit registers on the shared register bus.
REQ-002 SHALL have parameter ADDR_W, default 3: requester address width; NUM_REGS <= 2**ADDR_W.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port clk, input, 1: single clock; all state changes on posedge clk.
REQ-005 SHALL have ports a_req/b_req, input, 1 each: access request from requester A/B.
REQ-006 SHALL have ports a_we/b_we, input, 1 each: 1 = write, 0 = read.
REQ-007 SHALL have ports a_addr/b_addr, input, ADDR_W each: register index.
REQ-008 SHALL have ports a_wdata/b_wdata, input, 8 each: write data.
REQ-009 SHALL have ports a_ack/b_ack, output, 1 each: one-cycle completion pulse.
REQ-010 SHALL have ports a_rdata/b_rdata, output, 8 each: read data, valid while the matching ack is high.
REQ-011 SHALL have port reg_cs, output, NUM_REGS: one-hot register chip selects.
REQ-012 SHALL have port reg_we, output, 1: write enable to the selected register.
REQ-013 SHALL have port reg_wdata, output, 8: write data to the registers.
REQ-014 SHALL have port reg_rdata, input, 8: shared read bus; driven by the selected register while cs=1 and we=0, high-Z otherwise.

Function
REQ-015 SHALL implement the FSM IDLE -> ACCESS -> DONE -> IDLE, one cycle in each of ACCESS and DONE.
REQ-016 In IDLE with any req high, SHALL grant one requester, latch its we/addr/wdata, and enter ACCESS at the next edge.
REQ-017 In IDLE with no req high, SHALL remain in IDLE.
REQ-018 SHALL arbitrate round-robin: when both reqs are high, the requester not granted most recently wins; the pointer updates only on a grant.
REQ-019 In ACCESS, registered outputs SHALL drive reg_cs = onehot(addr), reg_we = latched we, reg_wdata = latched wdata; all three are 0 in every other state.
REQ-020 In ACCESS with a read, SHALL sample reg_rdata at the edge leaving ACCESS.
REQ-021 In DONE, SHALL assert the granted requester's ack for exactly one cycle; the other ack stays 0.
REQ-022 rdata SHALL equal the sampled value for reads and 8'h00 for writes; rdata holds its value outside ack.
REQ-023 Latency: with req high in cycle 0 and the arbiter idle, ack SHALL be high in cycle 2; throughput is one access per 3 cycles.
REQ-024 A requester SHALL drop req on the edge at which it samples ack high; the arbiter SHALL NOT sample req in DONE.
REQ-025 If req drops during ACCESS, the transaction SHALL still complete and ack SHALL still pulse.
REQ-026 If addr >= NUM_REGS, SHALL assert no reg_cs bit and no reg_we in ACCESS, and SHALL ack with rdata = 8'hFF for reads and 8'h00 for writes.
REQ-027 SHALL never assert more than one reg_cs bit and never assert both acks in the same cycle.

Reset
REQ-028 While rst is high, the FSM SHALL be in IDLE, the round-robin pointer SHALL favour A, and reg_cs, reg_we, reg_wdata, a_ack, b_ack, a_rdata and b_rdata SHALL all be 0.
REQ-029 Reset asserted mid-transaction SHALL abandon the access immediately with no ack and no further cs; the first grant after reset release is no earlier than the first clk edge with rst low.

Structure
REQ-030 Shared package reg_bus_pkg SHALL hold the FSM state enum, the default ADDR_W/NUM_REGS values, and BAD_ADDR_RDATA = 8'hFF.
REQ-031 Address decode SHALL be one sub-module reg_addr_decode (addr -> one-hot NUM_REGS vector plus out_of_range flag).

Verification
REQ-032 Write: A writes 0x5A to reg 3 -> reg_cs = 8'b0000_1000 with reg_we=1 for 1 cycle, a_ack in cycle 2, register then holds 0x5A.
REQ-033 Read: reg 3 holds 0x5A, B reads it -> reg_cs[3]=1 with reg_we=0, b_ack in cycle 2 with b_rdata=0x5A.
REQ-034 Contention: A and B request together continuously -> grants alternate A, B, A, B; acks 3 cycles apart; never simultaneous.
REQ-035 Out of range: NUM_REGS=6, A reads addr 7 -> reg_cs=0 throughout, a_ack with a_rdata=0xFF; write to addr 6 acks with no register change.
REQ-036 Reset in ACCESS: rst pulsed during a write cycle -> all outputs 0 at once, no ack, next contention grants A first.
REQ-037 Early req drop: A deasserts req in ACCESS -> a_ack still pulses in cycle 2 and the write still commits.
